uart_byte_tx: RTL and testbench

Serial byte transmitter that drives the board's `uart_tx` pin. It is the stage directly downstream of the 40-bit packet sequencer. The sequencer presents one byte plus a `send_go` strobe; this block serialises the byte as an asynchronous UART frame (start, 8 data bits LSB first, optional parity, 1 stop bit). It returns a one-cycle `tx_done` pulse, which the sequencer uses to advance to the next byte.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_byte_tx.sv | 100 ++++++++++
 tb/tb_uart_byte_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, frame lengths and the baud divisor helper.
// Used by the transmitter now and by the receiver later.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned FRAME_LEN_NOPAR = 10;
    localparam int unsigned FRAME_LEN_PAR   = 11;

    typedef enum logic {
        StIdle,
        StSend
    } tx_state_e;

    // Clocks per bit; truncation error against the nominal rate is accepted.
    function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period divider: counts 0..DIV-1 while enabled, held at zero while disabled.
// bit_tick is high for the single cycle at terminal count.
module uart_baud_cnt #(
    parameter int unsigned DIV = 434
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic enable,
    output logic bit_tick
);

    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    logic [CntW-1:0] cnt;

    assign bit_tick = enable && (cnt == LastCnt);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!enable || bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Emits a one-cycle tx_done at frame completion; that cycle can also accept the next byte.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter int unsigned PARITY   = 0
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       send_go,
    input  logic [7:0] data,
    output logic       uart_tx,
    output logic       tx_done,
    output logic       busy
);

    localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam logic [3:0] FrameLen =
        4'((PARITY == PAR_NONE) ? FRAME_LEN_NOPAR : FRAME_LEN_PAR);
    localparam logic [3:0] LastDataIdx = 4'd8;
    localparam logic [3:0] ParityIdx   = 4'd9;

    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_byte_tx: CLK_FREQ / BAUD must be at least 2");
    end

    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_byte_tx: PARITY must be 0 (none), 1 (odd) or 2 (even)");
    end

    tx_state_e  state;
    logic [3:0] bit_idx;
    logic [3:0] next_idx;
    logic [7:0] shreg;
    logic       par_bit;
    logic       baud_en;
    logic       bit_tick;

    assign baud_en  = (state == StSend);
    assign next_idx = bit_idx + 4'd1;

    uart_baud_cnt #(
        .DIV(BAUD_DIV)
    ) u_baud_cnt (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .enable  (baud_en),
        .bit_tick(bit_tick)
    );

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= StIdle;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
            tx_done <= 1'b0;
            busy    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (send_go) begin
                        shreg   <= data;
                        par_bit <= (PARITY == PAR_ODD) ? ~^data : ^data;
                        bit_idx <= '0;
                        uart_tx <= 1'b0;
                        busy    <= 1'b1;
                        state   <= StSend;
                    end
                end
                StSend: begin
                    // uart_tx is loaded with the bit that starts on the next period.
                    if (bit_tick) begin
                        bit_idx <= next_idx;
                        if (next_idx == FrameLen) begin
                            bit_idx <= '0;
                            uart_tx <= 1'b1;
                            tx_done <= 1'b1;
                            busy    <= 1'b0;
                            state   <= StIdle;
                        end else if (next_idx <= LastDataIdx) begin
                            uart_tx <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end else if (next_idx == ParityIdx && PARITY != PAR_NONE) begin
                            uart_tx <= par_bit;
                        end else begin
                            uart_tx <= 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: three instances (no/odd/even parity) at BAUD_DIV = 10.
// Stimulus queues hand-computed frames; a negedge monitor checks every line cycle.
module tb_uart_byte_tx;

    localparam int D = 10;

    typedef struct packed {
        logic [10:0] bits;   // bit0 = start bit, transmitted LSB first
        logic        abort;  // frame is expected to be cut short by reset
        logic        b2b;    // frame must start exactly one frame period after the previous
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] go = 3'b000;
    logic [7:0] dat0 = 8'h00;
    logic [7:0] dat1 = 8'h00;
    logic [7:0] dat2 = 8'h00;
    logic [2:0] utx;
    logic [2:0] dn;
    logic [2:0] bsy;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    bit   end_req = 1'b0;
    bit   end_ack = 1'b0;

    always #5 clk = ~clk;

    uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(0)) dut0 (
        .sys_clk(clk), .rst_n(rst_n), .send_go(go[0]), .data(dat0),
        .uart_tx(utx[0]), .tx_done(dn[0]), .busy(bsy[0])
    );
    uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(1)) dut1 (
        .sys_clk(clk), .rst_n(rst_n), .send_go(go[1]), .data(dat1),
        .uart_tx(utx[1]), .tx_done(dn[1]), .busy(bsy[1])
    );
    uart_byte_tx #(.CLK_FREQ(1_000_000), .BAUD(100_000), .PARITY(2)) dut2 (
        .sys_clk(clk), .rst_n(rst_n), .send_go(go[2]), .data(dat2),
        .uart_tx(utx[2]), .tx_done(dn[2]), .busy(bsy[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [10:0] bits, input logic ab, input logic bb);
        exp_t e;
        e.bits  = bits;
        e.abort = ab;
        e.b2b   = bb;
        return e;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one process owns all per-instance tracking state.
    initial begin
        int   cnt[3];
        bit   active[3];
        int   last_start[3];
        exp_t cur[3];
        for (int i = 0; i < 3; i++) begin
            cnt[i] = 0;
            active[i] = 1'b0;
            last_start[i] = 0;
            cur[i] = '0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                int nb;
                nb = (i == 0) ? 10 : 11;
                if (!active[i]) begin
                    if (bsy[i]) begin
                        bit got;
                        got = 1'b0;
                        case (i)
                            0: if (q0.size() > 0) begin cur[i] = q0.pop_front(); got = 1'b1; end
                            1: if (q1.size() > 0) begin cur[i] = q1.pop_front(); got = 1'b1; end
                            default:
                               if (q2.size() > 0) begin cur[i] = q2.pop_front(); got = 1'b1; end
                        endcase
                        if (!got) begin
                            check($sformatf("frame_expected[%0d]", i), 32'(got), 32'(1));
                            cur[i] = mk(11'h7FF, 1'b0, 1'b0);
                        end
                        if (cur[i].b2b)
                            check($sformatf("b2b_period[%0d]", i),
                                  32'(cyc - last_start[i]), 32'(nb * D + 1));
                        last_start[i] = cyc;
                        active[i] = 1'b1;
                        cnt[i] = 0;
                    end else begin
                        check($sformatf("idle_tx_busy_done[%0d]", i),
                              32'({utx[i], bsy[i], dn[i]}), 32'(3'b100));
                    end
                end
                if (active[i]) begin
                    if (!rst_n) begin
                        check($sformatf("abort_expected[%0d]", i), 32'(cur[i].abort), 32'(1));
                        check($sformatf("abort_tx_busy_done[%0d]", i),
                              32'({utx[i], bsy[i], dn[i]}), 32'(3'b100));
                        active[i] = 1'b0;
                    end else if (cnt[i] < nb * D) begin
                        check($sformatf("line_bit%0d[%0d]", cnt[i] / D, i),
                              32'(utx[i]), 32'(cur[i].bits[cnt[i] / D]));
                        check($sformatf("busy_done_in_frame[%0d]", i),
                              32'({bsy[i], dn[i]}), 32'(2'b10));
                        cnt[i]++;
                    end else begin
                        check($sformatf("done_tx_busy_done[%0d]", i),
                              32'({utx[i], bsy[i], dn[i]}), 32'(3'b101));
                        check($sformatf("not_aborted[%0d]", i), 32'(cur[i].abort), 32'(0));
                        active[i] = 1'b0;
                    end
                end
            end
            if (end_req && !end_ack) begin
                check("queues_drained", 32'(q0.size() + q1.size() + q2.size()), 32'(0));
                check("frames_idle", 32'({active[0], active[1], active[2]}), 32'(0));
                end_ack = 1'b1;
            end
        end
    end

    initial begin
        // Reset, then a long idle stretch with no requests.
        tick(5);
        rst_n = 1'b1;
        tick(200);

        // 8'hA5 without parity; data changes right after the accepting edge.
        q0.push_back(mk(11'b0_1_10100101_0, 1'b0, 1'b0));
        go[0] = 1'b1; dat0 = 8'hA5;
        tick(1);
        go[0] = 1'b0; dat0 = 8'hFF;
        tick(120);

        // Odd and even parity on 8'hA5, then odd parity on 8'h00.
        q1.push_back(mk(11'b1_1_10100101_0, 1'b0, 1'b0));
        q2.push_back(mk(11'b1_0_10100101_0, 1'b0, 1'b0));
        go[1] = 1'b1; dat1 = 8'hA5;
        go[2] = 1'b1; dat2 = 8'hA5;
        tick(1);
        go[1] = 1'b0; dat1 = 8'h00;
        go[2] = 1'b0; dat2 = 8'h00;
        tick(130);
        q1.push_back(mk(11'b1_1_00000000_0, 1'b0, 1'b0));
        go[1] = 1'b1; dat1 = 8'h00;
        tick(1);
        go[1] = 1'b0; dat1 = 8'hFF;
        tick(130);

        // send_go held high: 00/FF/00/FF back to back.
        q0.push_back(mk(11'b0_1_00000000_0, 1'b0, 1'b0));
        q0.push_back(mk(11'b0_1_11111111_0, 1'b0, 1'b1));
        q0.push_back(mk(11'b0_1_00000000_0, 1'b0, 1'b1));
        q0.push_back(mk(11'b0_1_11111111_0, 1'b0, 1'b1));
        go[0] = 1'b1; dat0 = 8'h00;
        tick(1);
        dat0 = 8'hFF;
        tick(101);
        dat0 = 8'h00;
        tick(101);
        dat0 = 8'hFF;
        tick(101);
        go[0] = 1'b0;
        tick(120);

        // A request 30 cycles into a frame is ignored.
        q0.push_back(mk(11'b0_1_11000011_0, 1'b0, 1'b0));
        go[0] = 1'b1; dat0 = 8'hC3;
        tick(1);
        go[0] = 1'b0;
        tick(29);
        go[0] = 1'b1; dat0 = 8'h3C;
        tick(1);
        go[0] = 1'b0;
        tick(120);

        // Reset 45 cycles into a frame aborts it; a fresh frame follows.
        q0.push_back(mk(11'b0_1_10010110_0, 1'b1, 1'b0));
        go[0] = 1'b1; dat0 = 8'h96;
        tick(1);
        go[0] = 1'b0;
        tick(44);
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(5);
        q0.push_back(mk(11'b0_1_01011010_0, 1'b0, 1'b0));
        go[0] = 1'b1; dat0 = 8'h5A;
        tick(1);
        go[0] = 1'b0; dat0 = 8'h00;
        tick(120);

        end_req = 1'b1;
        for (int k = 0; k < 10 && !end_ack; k++) @(posedge clk);
        if (!end_ack) begin
            $display("FAIL end_handshake: got 0 expected 1");
            $fatal(1, "monitor did not respond");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
